// File: rtl/input_debouncer.sv
// Multi-channel synchroniser and debouncer for raw board inputs.
// Each channel passes through a two-stage synchroniser, then must disagree
// with the accepted level for DEBOUNCE_CYCLES consecutive clocks before the
// new level is taken. Every accepted transition yields a one-cycle rise or
// fall pulse, and o_changed flags any pulse in the same cycle.
module input_debouncer #(
    parameter int           N               = 1,
    parameter int           DEBOUNCE_CYCLES = 50000,
    parameter logic [N-1:0] RESET_VAL       = {N{1'b1}}
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] i_raw,
    output logic [N-1:0] o_level,
    output logic [N-1:0] o_rise,
    output logic [N-1:0] o_fall,
    output logic         o_changed
);

    // A single-cycle debounce still needs a one-bit counter so the
    // vectors below stay legal; it simply never leaves zero.
    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]         sync_ff1;
    logic [N-1:0]         sync_q;
    logic [N-1:0]         level_q;
    logic [N-1:0]         rise_q;
    logic [N-1:0]         fall_q;
    logic                 changed_q;
    logic [N-1:0][CW-1:0] cnt_q;

    logic [N-1:0]         level_d;
    logic [N-1:0]         rise_d;
    logic [N-1:0]         fall_d;
    logic [N-1:0][CW-1:0] cnt_d;

    // Two-flop synchroniser; resets to the idle level so release is pulse-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff1 <= RESET_VAL;
            sync_q   <= RESET_VAL;
        end else begin
            sync_ff1 <= i_raw;
            sync_q   <= sync_ff1;
        end
    end

    // Per-channel counter: any agreement with the accepted level clears it, so
    // bounces never accumulate; the last mismatch cycle flips the level.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = '0;
        for (int i = 0; i < N; i++) begin
            if (sync_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync_q[i];
                    rise_d[i]  = sync_q[i];
                    fall_d[i]  = ~sync_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Debounce state and output pulses; o_changed is computed from the same
    // next-state pulses so it lines up with them exactly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q   <= RESET_VAL;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= |(rise_d | fall_d);
            cnt_q     <= cnt_d;
        end
    end

    assign o_level   = level_q;
    assign o_rise    = rise_q;
    assign o_fall    = fall_q;
    assign o_changed = changed_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with N=3, D=4, RESET_VAL=3'b111.
// Inputs change 1ns after a rising edge, so the following edge is the
// sampling edge 0; a clean change shows on o_level after the sixth tick.
module tb_input_debouncer;

    logic       clk;
    logic       reset_n;
    logic [2:0] i_raw;
    logic [2:0] o_level;
    logic [2:0] o_rise;
    logic [2:0] o_fall;
    logic       o_changed;

    int pass_count  = 0;
    int check_count = 0;

    input_debouncer #(
        .N               (3),
        .DEBOUNCE_CYCLES (4),
        .RESET_VAL       (3'b111)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_raw     (i_raw),
        .o_level   (o_level),
        .o_rise    (o_rise),
        .o_fall    (o_fall),
        .o_changed (o_changed)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks that the channel levels are as expected and no pulse is present.
    task automatic check_idle(input string tag, input logic [2:0] exp_level);
        check_output({tag, "_level"},   8'(o_level),   8'(exp_level));
        check_output({tag, "_rise"},    8'(o_rise),    8'd0);
        check_output({tag, "_fall"},    8'(o_fall),    8'd0);
        check_output({tag, "_changed"}, 8'(o_changed), 8'd0);
    endtask

    // Drives a raw input pattern, then steps the given number of edges
    // requiring a quiet output at the given level after each one.
    task automatic apply_stimulus(input string tag, input logic [2:0] raw,
                                  input int cycles, input logic [2:0] exp_level);
        i_raw = raw;
        for (int k = 0; k < cycles; k++) begin
            tick();
            check_idle(tag, exp_level);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        i_raw   = 3'b111;
        repeat (3) tick();
        check_idle("in_reset", 3'b111);

        // 1: release with idle inputs, 20 quiet cycles
        reset_n = 1'b1;
        apply_stimulus("release", 3'b111, 20, 3'b111);

        // 2: clean fall on channel 0, flips at edge 5
        apply_stimulus("ch0_wait", 3'b110, 5, 3'b111);
        tick();
        check_output("ch0_fall_level",   8'(o_level),   8'h06);
        check_output("ch0_fall_pulse",   8'(o_fall),    8'h01);
        check_output("ch0_fall_rise",    8'(o_rise),    8'h00);
        check_output("ch0_fall_changed", 8'(o_changed), 8'h01);
        tick();
        check_idle("ch0_after", 3'b110);
        apply_stimulus("ch0_hold", 3'b110, 4, 3'b110);

        // 3: channel 1 bounces with 3-cycle widths, then settles low
        apply_stimulus("ch1_b0", 3'b100, 3, 3'b110);
        apply_stimulus("ch1_b1", 3'b110, 3, 3'b110);
        apply_stimulus("ch1_b2", 3'b100, 3, 3'b110);
        apply_stimulus("ch1_b3", 3'b110, 3, 3'b110);
        apply_stimulus("ch1_settle", 3'b100, 5, 3'b110);
        tick();
        check_output("ch1_fall_level",   8'(o_level),   8'h04);
        check_output("ch1_fall_pulse",   8'(o_fall),    8'h02);
        check_output("ch1_fall_rise",    8'(o_rise),    8'h00);
        check_output("ch1_fall_changed", 8'(o_changed), 8'h01);
        tick();
        check_idle("ch1_after", 3'b100);

        // 4: 3-cycle glitch on channel 2 is rejected
        apply_stimulus("ch2_glitch", 3'b000, 3, 3'b100);
        apply_stimulus("ch2_back",   3'b100, 8, 3'b100);

        // 5: simultaneous rise on channel 0 and fall on channel 2
        apply_stimulus("dual_wait", 3'b001, 5, 3'b100);
        tick();
        check_output("dual_level",   8'(o_level),   8'h01);
        check_output("dual_rise",    8'(o_rise),    8'h01);
        check_output("dual_fall",    8'(o_fall),    8'h04);
        check_output("dual_changed", 8'(o_changed), 8'h01);
        tick();
        check_idle("dual_after", 3'b001);
        apply_stimulus("dual_hold", 3'b001, 3, 3'b001);

        // 6: reset mid-count discards the pending rise on channel 1
        apply_stimulus("mid_count", 3'b011, 4, 3'b001);
        reset_n = 1'b0;
        #1;
        check_idle("async_reset", 3'b111);
        i_raw = 3'b111;
        repeat (2) tick();
        check_idle("held_reset", 3'b111);
        reset_n = 1'b1;
        apply_stimulus("re_release", 3'b111, 20, 3'b111);

        // A clean fall after reset still takes the full debounce time.
        apply_stimulus("post_wait", 3'b011, 5, 3'b111);
        tick();
        check_output("post_level", 8'(o_level), 8'h03);
        check_output("post_fall",  8'(o_fall),  8'h04);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
